// File: rtl/pipelined_rv32_core.sv
// Five-stage in-order RV32 subset core (IF/ID/EX/MEM/WB) with integrated memories.
// EX forwarding, load-use stall and ID-stage beq resolution with a one-slot flush.
module pipelined_rv32_core (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_SRA = 3'd6;

  logic [31:0] r_imem [0:255];
  logic [31:0] r_dmem [0:31];
  logic [31:0] r_regs [0:31];
  logic [31:0] r_pc;

  logic [31:0] r_ifid_pc, r_ifid_instr;

  logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;
  logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
  logic [2:0]  r_idex_alu_op;
  logic        r_idex_alu_src, r_idex_reg_write, r_idex_mem_read, r_idex_mem_write, r_idex_mem_to_reg;

  logic [31:0] r_exmem_alu, r_exmem_sdata;
  logic [4:0]  r_exmem_rd;
  logic        r_exmem_reg_write, r_exmem_mem_write, r_exmem_mem_to_reg;

  logic [31:0] r_memwb_alu, r_memwb_mdata;
  logic [4:0]  r_memwb_rd;
  logic        r_memwb_reg_write, r_memwb_mem_to_reg;

  // ---------------- ID: decode ----------------
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm;
  logic [2:0]  w_alu_op;
  logic        w_alu_src, w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_branch;

  assign w_opcode = r_ifid_instr[6:0];
  assign w_rd     = r_ifid_instr[11:7];
  assign w_funct3 = r_ifid_instr[14:12];
  assign w_rs1    = r_ifid_instr[19:15];
  assign w_rs2    = r_ifid_instr[24:20];
  assign w_funct7 = r_ifid_instr[31:25];
  assign w_imm_i  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
  assign w_imm_s  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
  assign w_imm_b  = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                     r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};

  // NOTE: every output gets a default first so unmatched encodings decode to a NOP and no latch is inferred.
  always_comb begin
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_imm        = 32'd0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b111}: w_alu_op = ALU_AND;
          {7'b0000000, 3'b100}: w_alu_op = ALU_XOR;
          {7'b0000000, 3'b001}: w_alu_op = ALU_SLL;
          {7'b0000000, 3'b000}: w_alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: w_alu_op = ALU_SUB;
          {7'b0000001, 3'b000}: w_alu_op = ALU_MUL;
          default:              w_reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        if (w_funct3 == 3'b000) begin
          w_reg_write = 1'b1;
          w_alu_src   = 1'b1;
          w_imm       = w_imm_i;
        end else if (w_funct3 == 3'b101 && w_funct7 == 7'b0100000) begin
          w_reg_write = 1'b1;
          w_alu_src   = 1'b1;
          w_alu_op    = ALU_SRA;
          w_imm       = w_imm_i;
        end
      end
      OP_LW: if (w_funct3 == 3'b010) begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_imm        = w_imm_i;
      end
      OP_SW: if (w_funct3 == 3'b010) begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_s;
      end
      OP_BEQ: if (w_funct3 == 3'b000) begin
        w_branch = 1'b1;
        w_imm    = w_imm_b;
      end
      default: ;
    endcase
  end

  // Register file reads are write-first against the instruction retiring in WB.
  logic [31:0] w_wb_data, w_rd1, w_rd2, w_branch_target;
  logic        w_stall, w_taken, w_flush;

  assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 :
                 (r_memwb_reg_write && r_memwb_rd == w_rs1) ? w_wb_data : r_regs[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 :
                 (r_memwb_reg_write && r_memwb_rd == w_rs2) ? w_wb_data : r_regs[w_rs2];

  assign w_stall = r_idex_mem_read && (r_idex_rd != 5'd0) &&
                   (r_idex_rd == w_rs1 || r_idex_rd == w_rs2);
  assign w_taken = w_branch && (w_rd1 == w_rd2) && !w_stall;
  assign w_flush = w_taken;
  assign w_branch_target = r_ifid_pc + w_imm_b;

  // ---------------- IF ----------------
  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc         <= 32'd0;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= 32'd0;
    end else begin
      if (start_i && !w_stall)
        r_pc <= w_taken ? w_branch_target : r_pc + 32'd4;
      if (!w_stall) begin
        // While halted a bubble enters ID so the held PC is not issued repeatedly.
        if (w_flush || !start_i) begin
          r_ifid_pc    <= 32'd0;
          r_ifid_instr <= 32'd0;
        end else begin
          r_ifid_pc    <= r_pc;
          r_ifid_instr <= r_imem[r_pc[9:2]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex_rd1 <= '0; r_idex_rd2 <= '0; r_idex_imm <= '0;
      r_idex_rs1 <= '0; r_idex_rs2 <= '0; r_idex_rd  <= '0;
      r_idex_alu_op <= '0; r_idex_alu_src <= 1'b0; r_idex_reg_write <= 1'b0;
      r_idex_mem_read <= 1'b0; r_idex_mem_write <= 1'b0; r_idex_mem_to_reg <= 1'b0;
    end else begin
      r_idex_rd1 <= w_rd1; r_idex_rd2 <= w_rd2; r_idex_imm <= w_imm;
      r_idex_rs1 <= w_rs1; r_idex_rs2 <= w_rs2; r_idex_rd  <= w_rd;
      r_idex_alu_op     <= w_stall ? ALU_ADD : w_alu_op;
      r_idex_alu_src    <= w_alu_src    && !w_stall;
      r_idex_reg_write  <= w_reg_write  && !w_stall;
      r_idex_mem_read   <= w_mem_read   && !w_stall;
      r_idex_mem_write  <= w_mem_write  && !w_stall;
      r_idex_mem_to_reg <= w_mem_to_reg && !w_stall;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;

  always_comb begin
    if (r_exmem_reg_write && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs1)      w_fwd_a = r_exmem_alu;
    else if (r_memwb_reg_write && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs1) w_fwd_a = w_wb_data;
    else                                                                          w_fwd_a = r_idex_rd1;
    if (r_exmem_reg_write && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs2)      w_fwd_b = r_exmem_alu;
    else if (r_memwb_reg_write && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs2) w_fwd_b = w_wb_data;
    else                                                                          w_fwd_b = r_idex_rd2;
  end

  assign w_alu_b = r_idex_alu_src ? r_idex_imm : w_fwd_b;

  always_comb begin
    case (r_idex_alu_op)
      ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
      ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
      ALU_XOR: w_alu_res = w_fwd_a ^ w_alu_b;
      ALU_SLL: w_alu_res = w_fwd_a << w_alu_b[4:0];
      ALU_MUL: w_alu_res = w_fwd_a * w_alu_b;
      ALU_SRA: w_alu_res = $signed(w_fwd_a) >>> w_alu_b[4:0];
      default: w_alu_res = w_fwd_a + w_alu_b;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_exmem_alu <= '0; r_exmem_sdata <= '0; r_exmem_rd <= '0;
      r_exmem_reg_write <= 1'b0; r_exmem_mem_write <= 1'b0; r_exmem_mem_to_reg <= 1'b0;
    end else begin
      r_exmem_alu        <= w_alu_res;
      r_exmem_sdata      <= w_fwd_b;
      r_exmem_rd         <= r_idex_rd;
      r_exmem_reg_write  <= r_idex_reg_write;
      r_exmem_mem_write  <= r_idex_mem_write;
      r_exmem_mem_to_reg <= r_idex_mem_to_reg;
    end
  end

  // ---------------- MEM / WB ----------------
  logic [31:0] w_mem_rdata;
  assign w_mem_rdata = r_dmem[r_exmem_alu[6:2]];

  // NOTE: memories have no reset; architectural contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (r_exmem_mem_write)
      r_dmem[r_exmem_alu[6:2]] <= r_exmem_sdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_memwb_alu <= '0; r_memwb_mdata <= '0; r_memwb_rd <= '0;
      r_memwb_reg_write <= 1'b0; r_memwb_mem_to_reg <= 1'b0;
    end else begin
      r_memwb_alu        <= r_exmem_alu;
      r_memwb_mdata      <= w_mem_rdata;
      r_memwb_rd         <= r_exmem_rd;
      r_memwb_reg_write  <= r_exmem_reg_write;
      r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
    end
  end

  assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_mdata : r_memwb_alu;

  always_ff @(posedge clk_i) begin
    if (r_memwb_reg_write && r_memwb_rd != 5'd0)
      r_regs[r_memwb_rd] <= w_wb_data;
  end

endmodule

// File: tb/tb_pipelined_rv32_core.sv
// Directed bench for pipelined_rv32_core: programs are written into instruction memory
// during reset and architectural state is checked through hierarchy.
module tb_pipelined_rv32_core;

  logic clk_i = 1'b0;
  logic rst_i;
  logic start_i;
  int   total = 0;
  int   bad = 0;
  int   n_stall = 0;
  int   n_flush = 0;

  pipelined_rv32_core dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (dut.w_stall) n_stall++;
      if (dut.w_flush) n_flush++;
    end
  end

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] srai(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] sh);
    return {7'b0100000, sh, rs1, 3'b101, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Hold reset, clear instruction memory and counters.
  task automatic begin_prog();
    rst_i   = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.r_imem[i] = 32'd0;
    n_stall = 0;
    n_flush = 0;
  endtask

  // Release reset on a falling edge; that edge is sample 0 (PC=0 being fetched).
  task automatic go();
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
  endtask

  initial begin
    // Reset state
    begin_prog();
    step(3);
    check("reset_pc", dut.r_pc, 32'd0);
    check("reset_ifid", dut.r_ifid_instr, 32'd0);
    check("reset_idex_we", {31'd0, dut.r_idex_reg_write}, 32'd0);
    check("reset_memwb_we", {31'd0, dut.r_memwb_reg_write}, 32'd0);

    // start_i low: PC holds
    @(negedge clk_i);
    rst_i = 1'b1;
    step(4);
    check("halt_pc", dut.r_pc, 32'd0);

    // Basic ALU
    begin_prog();
    dut.r_imem[0]  = addi(1, 0, 12'd5);
    dut.r_imem[1]  = addi(2, 0, 12'd3);
    dut.r_imem[3]  = rtype(7'b0000000, 3'b000, 3, 1, 2);
    dut.r_imem[5]  = rtype(7'b0100000, 3'b000, 4, 1, 2);
    dut.r_imem[7]  = rtype(7'b0000001, 3'b000, 5, 1, 2);
    dut.r_imem[9]  = rtype(7'b0000000, 3'b111, 6, 1, 2);
    dut.r_imem[11] = rtype(7'b0000000, 3'b100, 7, 1, 2);
    dut.r_imem[13] = rtype(7'b0000000, 3'b001, 8, 1, 2);
    dut.r_imem[14] = addi(9, 0, 12'hFF8);
    dut.r_imem[15] = srai(10, 9, 5'd1);
    go();
    step(25);
    check("alu_add", dut.r_regs[3], 32'd8);
    check("alu_sub", dut.r_regs[4], 32'd2);
    check("alu_mul", dut.r_regs[5], 32'd15);
    check("alu_and", dut.r_regs[6], 32'd1);
    check("alu_xor", dut.r_regs[7], 32'd6);
    check("alu_sll", dut.r_regs[8], 32'd40);
    check("alu_srai", dut.r_regs[10], 32'hFFFF_FFFC);
    check("alu_stalls", n_stall, 0);

    // Back-to-back forwarding
    begin_prog();
    dut.r_imem[0] = addi(1, 0, 12'd7);
    dut.r_imem[1] = rtype(7'b0000000, 3'b000, 2, 1, 1);
    dut.r_imem[2] = rtype(7'b0000000, 3'b000, 3, 2, 1);
    go();
    step(12);
    check("fwd_x2", dut.r_regs[2], 32'd14);
    check("fwd_x3", dut.r_regs[3], 32'd21);
    check("fwd_stalls", n_stall, 0);
    check("fwd_pc", dut.r_pc, 32'd48);

    // Store then load
    begin_prog();
    dut.r_imem[0] = addi(1, 0, 12'd9);
    dut.r_imem[1] = sw(1, 0, 12'd8);
    dut.r_imem[2] = lw(2, 0, 12'd8);
    go();
    step(12);
    check("st_mem2", dut.r_dmem[2], 32'd9);
    check("ld_x2", dut.r_regs[2], 32'd9);
    check("stld_stalls", n_stall, 0);

    // Load-use hazard
    begin_prog();
    dut.r_imem[0] = addi(9, 0, 12'd5);
    dut.r_imem[1] = sw(9, 0, 12'd0);
    dut.r_imem[4] = lw(1, 0, 12'd0);
    dut.r_imem[5] = addi(2, 1, 12'd1);
    go();
    step(6);
    check("lu_stall_s6", {31'd0, dut.w_stall}, 32'd1);
    check("lu_pc_s6", dut.r_pc, 32'd24);
    step(1);
    check("lu_pc_s7", dut.r_pc, 32'd24);
    step(1);
    check("lu_pc_s8", dut.r_pc, 32'd28);
    step(8);
    check("lu_mem0", dut.r_dmem[0], 32'd5);
    check("lu_x2", dut.r_regs[2], 32'd6);
    check("lu_stalls", n_stall, 1);

    // Taken and not-taken beq
    begin_prog();
    dut.r_imem[0] = addi(5, 0, 12'd0);
    dut.r_imem[1] = addi(1, 0, 12'd1);
    dut.r_imem[4] = beq(1, 1, 13'd12);
    dut.r_imem[5] = addi(5, 0, 12'd1);
    dut.r_imem[6] = addi(5, 0, 12'd2);
    dut.r_imem[7] = addi(6, 0, 12'd2);
    dut.r_imem[8] = beq(1, 0, 13'd8);
    dut.r_imem[9] = addi(8, 0, 12'd4);
    go();
    step(5);
    check("br_flush_s5", {31'd0, dut.w_flush}, 32'd1);
    step(1);
    check("br_pc_target", dut.r_pc, 32'd28);
    check("br_ifid_flushed", dut.r_ifid_instr, 32'd0);
    step(12);
    check("br_x5", dut.r_regs[5], 32'd0);
    check("br_x6", dut.r_regs[6], 32'd2);
    check("br_nt_x8", dut.r_regs[8], 32'd4);
    check("br_flushes", n_flush, 1);

    // Mid-run reset discards in-flight work, keeps architectural state
    begin_prog();
    dut.r_imem[0] = addi(12, 0, 12'd11);
    dut.r_imem[3] = addi(12, 0, 12'd99);
    go();
    step(7);
    check("rst_pre_x12", dut.r_regs[12], 32'd11);
    rst_i = 1'b0;
    #1;
    check("rst_pc", dut.r_pc, 32'd0);
    check("rst_memwb_we", {31'd0, dut.r_memwb_reg_write}, 32'd0);
    step(3);
    check("rst_x12_kept", dut.r_regs[12], 32'd11);
    check("rst_x6_kept", dut.r_regs[6], 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
